// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - opcode, key-index and FSM state definitions shared by the numpad decoder
package calc_pkg;

  localparam int KEY_STROBE_BIT = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_EQ  = 3'd4,
    OP_CLR = 3'd5
  } opcode_t;

  // Function keys sit in the fourth row and the last column of the matrix
  localparam logic [3:0] KEY_IDX_A = 4'd12;
  localparam logic [3:0] KEY_IDX_B = 4'd13;
  localparam logic [3:0] KEY_IDX_C = 4'd14;
  localparam logic [3:0] KEY_IDX_D = 4'd15;
  localparam logic [3:0] KEY_IDX_E = 4'd11;
  localparam logic [3:0] KEY_IDX_F = 4'd7;

  typedef enum logic {
    ST_ENTRY    = 1'b0,
    ST_CMD_WAIT = 1'b1
  } keydec_state_t;

endpackage

// File: rtl/numpad_keymap.sv
// rtl/numpad_keymap.sv - combinational key index to digit/opcode decode
module numpad_keymap
  import calc_pkg::*;
(
  input  logic [3:0] i_key_idx,
  output logic       o_is_digit,
  output logic [3:0] o_digit,
  output opcode_t    o_opcode
);

  always_comb begin
    o_is_digit = 1'b1;
    o_digit    = 4'd0;
    o_opcode   = OP_ADD;
    case (i_key_idx)
      4'd0:      o_digit = 4'd1;
      4'd1:      o_digit = 4'd4;
      4'd2:      o_digit = 4'd7;
      4'd3:      o_digit = 4'd0;
      4'd4:      o_digit = 4'd2;
      4'd5:      o_digit = 4'd5;
      4'd6:      o_digit = 4'd8;
      4'd8:      o_digit = 4'd3;
      4'd9:      o_digit = 4'd6;
      4'd10:     o_digit = 4'd9;
      KEY_IDX_A: begin o_is_digit = 1'b0; o_opcode = OP_ADD; end
      KEY_IDX_B: begin o_is_digit = 1'b0; o_opcode = OP_SUB; end
      KEY_IDX_C: begin o_is_digit = 1'b0; o_opcode = OP_MUL; end
      KEY_IDX_D: begin o_is_digit = 1'b0; o_opcode = OP_DIV; end
      KEY_IDX_E: begin o_is_digit = 1'b0; o_opcode = OP_EQ;  end
      KEY_IDX_F: begin o_is_digit = 1'b0; o_opcode = OP_CLR; end
      default:   o_digit = 4'd0;
    endcase
  end

endmodule

// File: rtl/numpad_key_decoder.sv
// rtl/numpad_key_decoder.sv - BCD operand entry and command handoff; KEYDEC_HOLDOFF_EN adds a post-accept strobe holdoff
module numpad_key_decoder
  import calc_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int HOLDOFF_CYCLES = 50000
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic [4:0]          i_key_event,
  output logic [4*DIGITS-1:0] o_operand,
  output logic [3:0]          o_digit_count,
  output logic                o_overflow,
  output logic                o_cmd_valid,
  output logic [2:0]          o_cmd_op,
  output logic [4*DIGITS-1:0] o_cmd_operand,
  input  logic                i_cmd_ready,
  output logic                o_key_dropped
);

  localparam int         W         = 4 * DIGITS;
  localparam logic [3:0] MAX_COUNT = 4'(DIGITS);

  keydec_state_t r_state, w_state_nxt;
  logic [W-1:0]  r_operand, w_operand_nxt;
  logic [3:0]    r_digit_count, w_count_nxt;
  logic          r_overflow, w_overflow_nxt;
  logic          r_cmd_valid, w_cmd_valid_nxt;
  opcode_t       r_cmd_op, w_cmd_op_nxt;
  logic [W-1:0]  r_cmd_operand, w_cmd_operand_nxt;
  logic          r_key_dropped, w_dropped_nxt;

  logic          w_strobe;
  logic          w_live;
  logic          w_accept;
  logic          w_is_digit;
  logic [3:0]    w_digit;
  opcode_t       w_opcode;

  numpad_keymap u_keymap (
    .i_key_idx  (i_key_event[3:0]),
    .o_is_digit (w_is_digit),
    .o_digit    (w_digit),
    .o_opcode   (w_opcode)
  );

  assign w_strobe = i_key_event[KEY_STROBE_BIT];

`ifdef KEYDEC_HOLDOFF_EN
  localparam int HW = (HOLDOFF_CYCLES < 1) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
  logic [HW-1:0] r_holdoff;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_holdoff <= '0;
    end else if (w_accept) begin
      r_holdoff <= HW'(HOLDOFF_CYCLES);
    end else if (r_holdoff != '0) begin
      r_holdoff <= r_holdoff - HW'(1);
    end
  end

  // Strobes inside the window vanish silently: neither accepted nor reported as dropped
  assign w_live = w_strobe && (r_holdoff == '0);
`else
  assign w_live = w_strobe && (HOLDOFF_CYCLES >= 0);
`endif

  assign w_accept = w_live && (r_state == ST_ENTRY);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_ENTRY;
      r_operand     <= '0;
      r_digit_count <= '0;
      r_overflow    <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_cmd_op      <= OP_ADD;
      r_cmd_operand <= '0;
      r_key_dropped <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_operand     <= w_operand_nxt;
      r_digit_count <= w_count_nxt;
      r_overflow    <= w_overflow_nxt;
      r_cmd_valid   <= w_cmd_valid_nxt;
      r_cmd_op      <= w_cmd_op_nxt;
      r_cmd_operand <= w_cmd_operand_nxt;
      r_key_dropped <= w_dropped_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_operand_nxt     = r_operand;
    w_count_nxt       = r_digit_count;
    w_overflow_nxt    = r_overflow;
    w_cmd_valid_nxt   = r_cmd_valid;
    w_cmd_op_nxt      = r_cmd_op;
    w_cmd_operand_nxt = r_cmd_operand;
    w_dropped_nxt     = 1'b0;
    case (r_state)
      ST_ENTRY: begin
        if (w_accept) begin
          if (w_is_digit) begin
            // A zero typed into an empty entry is a leading zero and is not stored
            if ((r_digit_count != 4'd0) || (w_digit != 4'd0)) begin
              if (r_digit_count < MAX_COUNT) begin
                w_operand_nxt = (r_operand << 4) | W'(w_digit);
                w_count_nxt   = r_digit_count + 4'd1;
              end else begin
                w_overflow_nxt = 1'b1;
              end
            end
          end else if (w_opcode == OP_CLR) begin
            w_operand_nxt     = '0;
            w_count_nxt       = '0;
            w_overflow_nxt    = 1'b0;
            w_cmd_operand_nxt = '0;
            w_cmd_op_nxt      = OP_CLR;
            w_cmd_valid_nxt   = 1'b1;
            w_state_nxt       = ST_CMD_WAIT;
          end else begin
            w_cmd_operand_nxt = r_operand;
            w_cmd_op_nxt      = w_opcode;
            w_cmd_valid_nxt   = 1'b1;
            w_state_nxt       = ST_CMD_WAIT;
          end
        end
      end
      ST_CMD_WAIT: begin
        w_dropped_nxt = w_live;
        if (r_cmd_valid && i_cmd_ready) begin
          w_cmd_valid_nxt = 1'b0;
          w_operand_nxt   = '0;
          w_count_nxt     = '0;
          w_overflow_nxt  = 1'b0;
          w_state_nxt     = ST_ENTRY;
        end
      end
      default: w_state_nxt = ST_ENTRY;
    endcase
  end

  assign o_operand     = r_operand;
  assign o_digit_count = r_digit_count;
  assign o_overflow    = r_overflow;
  assign o_cmd_valid   = r_cmd_valid;
  assign o_cmd_op      = r_cmd_op;
  assign o_cmd_operand = r_cmd_operand;
  assign o_key_dropped = r_key_dropped;

endmodule

// File: tb/tb_numpad_key_decoder.sv
// tb/tb_numpad_key_decoder.sv - randomized scoreboard bench for numpad_key_decoder
module tb_numpad_key_decoder;

  localparam int DIGITS  = 8;
  localparam int HOLDOFF = 10;
  localparam int W       = 4 * DIGITS;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic [4:0]   key_event = 5'd0;
  logic         cmd_ready = 1'b0;
  logic [W-1:0] o_operand;
  logic [3:0]   o_digit_count;
  logic         o_overflow;
  logic         o_cmd_valid;
  logic [2:0]   o_cmd_op;
  logic [W-1:0] o_cmd_operand;
  logic         o_key_dropped;

  numpad_key_decoder #(
    .DIGITS         (DIGITS),
    .HOLDOFF_CYCLES (HOLDOFF)
  ) dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_key_event   (key_event),
    .o_operand     (o_operand),
    .o_digit_count (o_digit_count),
    .o_overflow    (o_overflow),
    .o_cmd_valid   (o_cmd_valid),
    .o_cmd_op      (o_cmd_op),
    .o_cmd_operand (o_cmd_operand),
    .i_cmd_ready   (cmd_ready),
    .o_key_dropped (o_key_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] operand;
    logic [3:0]   count;
    logic         ovf;
    logic         valid;
    logic         drop;
  } snap_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] operand;
  } cmd_t;

  snap_t exp_q[$];
  cmd_t  cmd_q[$];
  int    checks   = 0;
  int    failures = 0;

  // Keypad legend by index; values 10..15 stand for keys A..F
  int KEYVAL[16]  = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};
  int DIG_IDX[10] = '{3, 0, 4, 8, 1, 5, 9, 2, 6, 10};
  int OP_IDX[6]   = '{12, 13, 14, 15, 11, 7};

  int m_digits[$];
  bit m_ovf      = 1'b0;
  bit m_wait     = 1'b0;
  int m_cyc      = 0;
  int m_last_acc = -1000000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] operand_value();
    logic [W-1:0] r;
    r = '0;
    foreach (m_digits[i]) r = (r << 4) | W'(m_digits[i]);
    return r;
  endfunction

  task automatic model_step(input bit strobe, input int idx, input bit ready);
    bit    live;
    bit    drop;
    int    v;
    cmd_t  c;
    snap_t s;
    live = strobe;
`ifdef KEYDEC_HOLDOFF_EN
    if (m_cyc - m_last_acc <= HOLDOFF) live = 1'b0;
`endif
    drop = 1'b0;
    if (m_wait) begin
      drop = live;
      if (ready) begin
        m_wait = 1'b0;
        m_digits.delete();
        m_ovf = 1'b0;
      end
    end else if (live) begin
      m_last_acc = m_cyc;
      v = KEYVAL[idx];
      if (v < 10) begin
        if (m_digits.size() == 0 && v == 0) begin
          m_ovf = m_ovf;
        end else if (m_digits.size() < DIGITS) begin
          m_digits.push_back(v);
        end else begin
          m_ovf = 1'b1;
        end
      end else if (v == 15) begin
        m_digits.delete();
        m_ovf     = 1'b0;
        c.op      = 3'd5;
        c.operand = '0;
        cmd_q.push_back(c);
        m_wait = 1'b1;
      end else begin
        c.op      = 3'(v - 10);
        c.operand = operand_value();
        cmd_q.push_back(c);
        m_wait = 1'b1;
      end
    end
    s.operand = operand_value();
    s.count   = 4'(m_digits.size());
    s.ovf     = m_ovf;
    s.valid   = m_wait;
    s.drop    = drop;
    exp_q.push_back(s);
    m_cyc++;
  endtask

  // Inputs set here are consumed by the following rising edge
  task automatic drive(input bit strobe, input int idx, input bit ready);
    @(posedge clk);
    #3;
    key_event = strobe ? {1'b1, 4'(idx)} : 5'd0;
    cmd_ready = ready;
    model_step(strobe, idx, ready);
  endtask

  task automatic press(input int idx, input bit ready);
    drive(1'b1, idx, ready);
    drive(1'b0, 0, ready);
`ifdef KEYDEC_HOLDOFF_EN
    repeat (HOLDOFF + 1) drive(1'b0, 0, ready);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_operand"}, o_operand, 0);
    check({tag, "_count"}, o_digit_count, 0);
    check({tag, "_overflow"}, o_overflow, 0);
    check({tag, "_cmd_valid"}, o_cmd_valid, 0);
    check({tag, "_cmd_op"}, o_cmd_op, 0);
    check({tag, "_cmd_operand"}, o_cmd_operand, 0);
    check({tag, "_key_dropped"}, o_key_dropped, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    key_event = 5'd0;
    cmd_ready = 1'b0;
    #1;
    check_all_zero("async_reset");
    cmd_q.delete();
    m_digits.delete();
    m_ovf      = 1'b0;
    m_wait     = 1'b0;
    m_last_acc = -1000000;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // State monitor: one expected snapshot per modelled edge
  initial begin
    snap_t s;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        check("mon_operand", o_operand, s.operand);
        check("mon_count", o_digit_count, s.count);
        check("mon_overflow", o_overflow, s.ovf);
        check("mon_cmd_valid", o_cmd_valid, s.valid);
        check("mon_key_dropped", o_key_dropped, s.drop);
      end
    end
  end

  // Command monitor: pops the scoreboard on every handshake
  initial begin
    cmd_t c;
    forever begin
      @(negedge clk);
      if (rst_n && o_cmd_valid && cmd_ready) begin
        if (cmd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cmd_unexpected: got op %0d operand %0h expected no command", o_cmd_op, o_cmd_operand);
        end else begin
          c = cmd_q.pop_front();
          check("cmd_op", o_cmd_op, c.op);
          check("cmd_operand", o_cmd_operand, c.operand);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit strobe;
    int idx;
    repeat (3) @(posedge clk);
    #3;
    check_all_zero("reset");
    rst_n = 1'b1;

    press(0, 1'b0);
    press(4, 1'b0);
    press(8, 1'b0);
    check("dir_123_operand", o_operand, 32'h0000_0123);
    check("dir_123_count", o_digit_count, 3);
    check("dir_123_valid", o_cmd_valid, 0);

    drive(1'b1, 12, 1'b0);
    repeat (5) begin
      drive(1'b0, 0, 1'b0);
      check("dir_add_valid_held", o_cmd_valid, 1);
      check("dir_add_op", o_cmd_op, 0);
      check("dir_add_operand", o_cmd_operand, 32'h0000_0123);
    end
    drive(1'b0, 0, 1'b1);
    check("dir_add_valid_6th", o_cmd_valid, 1);
    drive(1'b0, 0, 1'b0);
    check("dir_add_done_valid", o_cmd_valid, 0);
    check("dir_add_done_operand", o_operand, 0);
    check("dir_add_done_count", o_digit_count, 0);
    check("dir_add_op_held", o_cmd_op, 0);
    check("dir_add_operand_held", o_cmd_operand, 32'h0000_0123);
`ifdef KEYDEC_HOLDOFF_EN
    repeat (HOLDOFF + 1) drive(1'b0, 0, 1'b0);
`endif

    press(3, 1'b0);
    press(3, 1'b0);
    press(1, 1'b0);
    check("dir_lead0_operand", o_operand, 4);
    check("dir_lead0_count", o_digit_count, 1);
    press(7, 1'b0);
    press(0, 1'b1);
    foreach (DIG_IDX[i]) if (i > 0) press(DIG_IDX[i], 1'b0);
    check("dir_ovf_operand", o_operand, 32'h1234_5678);
    check("dir_ovf_count", o_digit_count, 8);
    check("dir_ovf_flag", o_overflow, 1);

    press(12, 1'b0);
    drive(1'b1, 5, 1'b0);
    drive(1'b0, 0, 1'b0);
    check("dir_drop_pulse", o_key_dropped, 1);
    check("dir_drop_operand", o_operand, operand_value());
    drive(1'b0, 0, 1'b0);
    check("dir_drop_end", o_key_dropped, 0);
    drive(1'b1, 5, 1'b1);
    drive(1'b0, 0, 1'b0);
    check("dir_drop_hs_pulse", o_key_dropped, 1);
    check("dir_drop_hs_valid", o_cmd_valid, 0);
    check("dir_drop_hs_operand", o_operand, 0);
`ifdef KEYDEC_HOLDOFF_EN
    repeat (HOLDOFF + 1) drive(1'b0, 0, 1'b0);
`endif

    press(2, 1'b0);
    press(2, 1'b0);
    check("dir_77_operand", o_operand, 32'h77);
    press(7, 1'b0);
    check("dir_clr_operand", o_operand, 0);
    check("dir_clr_op", o_cmd_op, 5);
    check("dir_clr_cmd_operand", o_cmd_operand, 0);
    check("dir_clr_valid", o_cmd_valid, 1);
    press(0, 1'b1);

    press(12, 1'b0);
    do_reset();

`ifdef KEYDEC_HOLDOFF_EN
    repeat (HOLDOFF + 1) drive(1'b0, 0, 1'b0);
    drive(1'b1, 0, 1'b0);
    repeat (4) drive(1'b0, 0, 1'b0);
    drive(1'b1, 4, 1'b0);
    drive(1'b0, 0, 1'b0);
    check("dir_hold_ignored", o_operand, 1);
    repeat (5) drive(1'b0, 0, 1'b0);
    drive(1'b1, 4, 1'b0);
    drive(1'b0, 0, 1'b0);
    check("dir_hold_accepted", o_operand, 32'h12);
`endif

    for (int n = 0; n < 3000; n++) begin
      if (n == 1000 || n == 2000) do_reset();
      strobe = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 9) < 7) idx = DIG_IDX[$urandom_range(0, 9)];
      else idx = OP_IDX[$urandom_range(0, 5)];
      drive(strobe, idx, ($urandom_range(0, 2) != 0));
    end

    repeat (4) drive(1'b0, 0, 1'b1);
    @(posedge clk);
    #2;
    check("end_cmd_q_empty", cmd_q.size(), 0);
    check("end_exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/numpad_key_decoder.md
# numpad_key_decoder

Consumer end of the numpad event interface. Takes the 5-bit key-event word produced by the keypad scanner (bit 4 = event strobe, bits 3:0 = key index), decodes each index into a digit or function key, and assembles a BCD operand. Operator keys hand the finished operand and an opcode to the calculator core over a valid/ready handshake. Sits between the scanner and the arithmetic core.

## Interface
Parameters:
- DIGITS, 8, operand length in BCD digits (1..15)
- HOLDOFF_CYCLES, 50000, post-accept ignore window; used only with KEYDEC_HOLDOFF_EN

Ports:
- clock  in  1  system clock (50 MHz)
- reset_n  in  1  reset; one clock, reset is asynchronous and active-low
- key_event  in  5  bit4 = one-cycle press strobe, [3:0] = key index; 5'b00000 = no event
- operand  out  4*DIGITS  current BCD entry, least significant digit in [3:0]
- digit_count  out  4  digits entered (0..DIGITS)
- overflow  out  1  sticky: a digit was refused because entry was full
- cmd_valid  out  1  command offered to core
- cmd_op  out  3  opcode, stable while cmd_valid
- cmd_operand  out  4*DIGITS  operand snapshot, stable while cmd_valid
- cmd_ready  in  1  core accepts command
- key_dropped  out  1  one-cycle pulse: a strobed event was discarded

## Operation
- Key index map (index = column*4 + row): 0→1, 1→4, 2→7, 3→0, 4→2, 5→5, 6→8, 7→F, 8→3, 9→6, 10→9, 11→E, 12→A, 13→B, 14→C, 15→D.
- Function keys → opcode: A=ADD 0, B=SUB 1, C=MUL 2, D=DIV 3, E=EQ 4, F=CLR 5; codes 6,7 unused.
- Event sampled only when key_event[4]=1; strobe with bit4=0 ignored entirely.
- FSM states: ENTRY, CMD_WAIT. Reset → ENTRY.
- ENTRY, digit key: if digit_count==0 and digit==0, no change (leading zero suppressed). Else if digit_count<DIGITS: operand ← {operand[4*DIGITS-5:0], digit}, digit_count+1. Else: no change, overflow←1.
- ENTRY, A–E: cmd_operand←operand, cmd_op←code, cmd_valid←1, → CMD_WAIT.
- ENTRY, F: operand, digit_count, overflow cleared; cmd_operand←0, cmd_op←CLR, cmd_valid←1, → CMD_WAIT.
- CMD_WAIT: on cmd_valid&cmd_ready: cmd_valid←0, operand←0, digit_count←0, overflow←0, → ENTRY. Any strobed event while in CMD_WAIT (including the handshake cycle) discarded, key_dropped pulses.
- cmd_op/cmd_operand hold value after handshake until next command.

## Timing
- Reset values: operand 0, digit_count 0, overflow 0, cmd_valid 0, cmd_op 0, cmd_operand 0, key_dropped 0.
- Event at edge N → operand/digit_count/cmd_valid updated visible after edge N (1-cycle latency).
- cmd_ready may be high before cmd_valid; earliest handshake is the cycle after the operator event.
- cmd_valid never deasserts without handshake; payload never changes while valid.
- First event accepted on the cycle after handshake completes.
- Async reset mid-handshake: command withdrawn, all state to reset values.

## Configuration
- KEYDEC_HOLDOFF_EN defined: after any accepted event, a counter ignores strobes for HOLDOFF_CYCLES clocks (ignored strobes do NOT pulse key_dropped); counter cleared by reset.
- Undefined: every strobe in ENTRY is accepted; no counter logic.

## Structure
- Shared package calc_pkg: opcode enum (ADD..CLR), key-index constants, KEY_STROBE_BIT=4.
- Sub-module numpad_keymap: combinational index → {is_digit, digit[3:0], opcode[2:0]}; FSM, entry register and holdoff counter in top.

## Test plan
- Reset, strobe keys 0(‘1’),4(‘2’),8(‘3’) → operand=32'h00000123, digit_count=3, cmd_valid=0.
- Enter 123, strobe 12(A), cmd_ready=0 for 5 cycles then 1 → cmd_valid held 6 cycles, cmd_op=0, cmd_operand=0x123; after handshake operand=0, digit_count=0.
- Strobe 3(‘0’) twice then 1(‘4’) → operand=4, digit_count=1; enter 9 digits with DIGITS=8 → 8 kept, overflow=1.
- In CMD_WAIT strobe 5(‘5’) → key_dropped one-cycle pulse, operand unchanged.
- Strobe 7(F) with operand 0x77 → operand=0, cmd_op=5, cmd_operand=0.
- With KEYDEC_HOLDOFF_EN, HOLDOFF_CYCLES=10: strobe ‘1’ at cycle 0 and ‘2’ at cycle 5 → operand=1; ‘2’ at cycle 12 → operand=0x12.
